// File: rtl/rcv_sequencer.sv
// UART receive sequencer: start-bit qualification, bit-centre strobes into the
// shift register, stop-bit check, buffer load and RX status flags.
module rcv_sequencer #(
  parameter int CLKS_PER_BIT = 10,
  parameter int NUM_BITS     = 9
) (
  input  logic clk,
  input  logic n_rst,
  input  logic serial_in,
  input  logic stop_bit,
  input  logic data_read,
  output logic shift_strobe,
  output logic load_buffer,
  output logic data_ready,
  output logic framing_error,
  output logic overrun_error,
  output logic rx_busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(NUM_BITS - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START_CHK = 3'd1;
  localparam logic [2:0] S_RECV      = 3'd2;
  localparam logic [2:0] S_STOP_CHK  = 3'd3;
  localparam logic [2:0] S_LOAD      = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_next_state;
  logic [CW-1:0] r_clk_cnt;
  logic [BW-1:0] r_bit_cnt;
  logic          r_prev_rx;
  logic          r_data_ready;
  logic          r_framing_error;
  logic          r_overrun_error;
  logic          w_start_edge;
  logic          w_bit_end;

  assign w_start_edge = r_prev_rx & ~serial_in;
  assign w_bit_end    = (r_state == S_RECV) && (r_clk_cnt == BIT_LAST);

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:      if (w_start_edge) w_next_state = S_START_CHK;
      S_START_CHK: if (r_clk_cnt == HALF_LAST) w_next_state = serial_in ? S_IDLE : S_RECV;
      S_RECV:      if (w_bit_end && (r_bit_cnt == LAST_BIT)) w_next_state = S_STOP_CHK;
      S_STOP_CHK:  w_next_state = stop_bit ? S_LOAD : S_IDLE;
      S_LOAD:      w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_prev_rx <= 1'b1;
    end else begin
      r_state   <= w_next_state;
      r_prev_rx <= serial_in;
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
          end
        end
        S_START_CHK: r_clk_cnt <= (r_clk_cnt == HALF_LAST) ? '0 : r_clk_cnt + 1'b1;
        S_RECV: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // A load always wins over a coincident data_read; the read then only cancels the overrun.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_data_ready    <= 1'b0;
      r_framing_error <= 1'b0;
      r_overrun_error <= 1'b0;
    end else begin
      if (r_state == S_LOAD)  r_data_ready <= 1'b1;
      else if (data_read)     r_data_ready <= 1'b0;

      if ((r_state == S_LOAD) && r_data_ready && !data_read) r_overrun_error <= 1'b1;
      else if (data_read)                                      r_overrun_error <= 1'b0;

      if ((r_state == S_IDLE) && w_start_edge)          r_framing_error <= 1'b0;
      else if ((r_state == S_STOP_CHK) && !stop_bit)    r_framing_error <= 1'b1;
    end
  end

  assign shift_strobe  = w_bit_end;
  assign load_buffer   = (r_state == S_LOAD);
  assign rx_busy       = (r_state != S_IDLE);
  assign data_ready    = r_data_ready;
  assign framing_error = r_framing_error;
  assign overrun_error = r_overrun_error;

endmodule

// File: tb/tb_rcv_sequencer.sv
// Self-checking bench for rcv_sequencer: a frame-timing model checked every cycle,
// plus literal expectations for the key cycles of each directed scenario.
module tb_rcv_sequencer;

  localparam int CPB   = 10;
  localparam int NB    = 9;
  localparam int HALF  = CPB / 2;
  localparam int STOPT = HALF + NB * CPB + 1;
  localparam int LOADT = STOPT + 1;

  logic clk = 1'b0;
  logic n_rst, serial_in, stop_bit, data_read;
  logic shift_strobe, load_buffer, data_ready, framing_error, overrun_error, rx_busy;

  int nChecks = 0;
  int nFail   = 0;

  rcv_sequencer #(.CLKS_PER_BIT(CPB), .NUM_BITS(NB)) dut (
    .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .stop_bit(stop_bit),
    .data_read(data_read), .shift_strobe(shift_strobe), .load_buffer(load_buffer),
    .data_ready(data_ready), .framing_error(framing_error),
    .overrun_error(overrun_error), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Model: a frame is a count of cycles since the start edge; every output follows from that count.
  bit mActive, mPrev, mReady, mFrame, mOver;
  int mT;

  always @(negedge clk) begin
    logic eStrobe, eLoad, nReady, nOver;
    if (!n_rst) begin
      checkOutput("rst_strobe", shift_strobe, 0);
      checkOutput("rst_load", load_buffer, 0);
      checkOutput("rst_ready", data_ready, 0);
      checkOutput("rst_frame", framing_error, 0);
      checkOutput("rst_over", overrun_error, 0);
      checkOutput("rst_busy", rx_busy, 0);
      mActive = 0; mPrev = 1; mReady = 0; mFrame = 0; mOver = 0; mT = 0;
    end else begin
      eLoad   = mActive && (mT == LOADT);
      eStrobe = mActive && (mT > HALF) && ((mT - HALF) % CPB == 0) && ((mT - HALF) / CPB <= NB);
      checkOutput("strobe", shift_strobe, eStrobe);
      checkOutput("load", load_buffer, eLoad);
      checkOutput("ready", data_ready, mReady);
      checkOutput("frame", framing_error, mFrame);
      checkOutput("over", overrun_error, mOver);
      checkOutput("busy", rx_busy, mActive);

      nReady = eLoad ? 1'b1 : (data_read ? 1'b0 : mReady);
      nOver  = data_read ? 1'b0 : mOver;
      if (eLoad && mReady && !data_read) nOver = 1'b1;
      mReady = nReady;
      mOver  = nOver;

      if (!mActive) begin
        if (mPrev && !serial_in) begin
          mActive = 1; mT = 1; mFrame = 0;
        end
      end else if (mT == HALF && serial_in) begin
        mActive = 0;
      end else if (mT == STOPT && !stop_bit) begin
        mActive = 0; mFrame = 1;
      end else if (mT == LOADT) begin
        mActive = 0;
      end else begin
        mT++;
      end
      mPrev = serial_in;
    end
  end

  int fStrobes, fFirst, fLast, fLoadC;
  logic fFrame1, fFrame97, fReady98, fOver98, fBusy5, fBusy6, rdReady, rdOver;
  logic [5:0] fRst;

  function automatic logic lineAt(int c, logic [7:0] d, logic s);
    int b;
    b = c / CPB;
    if (c < CPB) return 1'b0;
    if (c >= STOPT) return 1'b1;
    if (b <= 8) return d[b-1];
    return s;
  endfunction

  // Drives one frame, cycle 0 being the falling start edge; abortAt >= 0 pulls reset in that cycle.
  task automatic applyStimulus(input logic [7:0] d, input logic s, input bit readAtLoad, input int abortAt);
    fStrobes = 0; fFirst = -1; fLast = -1; fLoadC = -1;
    for (int c = 0; c <= LOADT + 1; c++) begin
      @(posedge clk); #1;
      serial_in = lineAt(c, d, s);
      stop_bit  = s;
      data_read = readAtLoad && (c == LOADT);
      if (c == abortAt) begin
        n_rst = 0; serial_in = 1; data_read = 0;
        #1 fRst = {shift_strobe, load_buffer, data_ready, framing_error, overrun_error, rx_busy};
        return;
      end
      #2;
      if (shift_strobe) begin
        fStrobes++;
        if (fFirst < 0) fFirst = c;
        fLast = c;
      end
      if (load_buffer && fLoadC < 0) fLoadC = c;
      if (c == 1) fFrame1 = framing_error;
      if (c == LOADT) fFrame97 = framing_error;
      if (c == LOADT + 1) begin fReady98 = data_ready; fOver98 = overrun_error; end
    end
    data_read = 0;
  endtask

  task automatic glitch();
    fStrobes = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1 serial_in = (c >= 3);
      #2;
      if (shift_strobe) fStrobes++;
      if (c == 5) fBusy5 = rx_busy;
      if (c == 6) fBusy6 = rx_busy;
    end
  endtask

  task automatic readPulse();
    @(posedge clk); #1 data_read = 1;
    @(posedge clk); #1 data_read = 0;
    #2 rdReady = data_ready; rdOver = overrun_error;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1 serial_in = 1; data_read = 0; end
  endtask

  initial begin
    n_rst = 0; serial_in = 1; stop_bit = 1; data_read = 0;
    @(posedge clk); #2;
    checkOutput("reset_busy", rx_busy, 0);
    checkOutput("reset_ready", data_ready, 0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1;
    idle(3);

    $display("[TB] valid frame 0xA5");
    applyStimulus(8'hA5, 1'b1, 0, -1);
    checkOutput("t1_strobes", fStrobes, 9);
    checkOutput("t1_first", fFirst, 15);
    checkOutput("t1_last", fLast, 95);
    checkOutput("t1_loadc", fLoadC, 97);
    checkOutput("t1_ready", fReady98, 1);
    checkOutput("t1_over", fOver98, 0);
    checkOutput("t1_frame", fFrame97, 0);
    readPulse();
    checkOutput("t1_read", rdReady, 0);
    idle(3);

    $display("[TB] start glitch");
    glitch();
    checkOutput("t2_busy5", fBusy5, 1);
    checkOutput("t2_busy6", fBusy6, 0);
    checkOutput("t2_strobes", fStrobes, 0);
    idle(2);

    $display("[TB] framing error frame");
    applyStimulus(8'h3C, 1'b0, 0, -1);
    checkOutput("t3_strobes", fStrobes, 9);
    checkOutput("t3_loadc", fLoadC, -1);
    checkOutput("t3_frame", fFrame97, 1);

    $display("[TB] overrun pair");
    applyStimulus(8'h11, 1'b1, 0, -1);
    checkOutput("t4_frame_clr", fFrame1, 0);
    checkOutput("t4a_over", fOver98, 0);
    checkOutput("t4a_ready", fReady98, 1);
    applyStimulus(8'h22, 1'b1, 0, -1);
    checkOutput("t4b_over", fOver98, 1);
    readPulse();
    checkOutput("t4_rd_ready", rdReady, 0);
    checkOutput("t4_rd_over", rdOver, 0);
    idle(2);

    $display("[TB] read coincident with load");
    applyStimulus(8'h5A, 1'b1, 0, -1);
    applyStimulus(8'hC3, 1'b1, 1, -1);
    checkOutput("t5_ready", fReady98, 1);
    checkOutput("t5_over", fOver98, 0);
    readPulse();
    idle(2);

    $display("[TB] reset mid-frame");
    applyStimulus(8'hFF, 1'b1, 0, 50);
    for (int i = 0; i < 6; i++) checkOutput("t6_rst_out", fRst[i], 0);
    idle(3);
    @(posedge clk); #1 n_rst = 1;
    idle(3);
    applyStimulus(8'h81, 1'b1, 0, -1);
    checkOutput("t6_loadc", fLoadC, 97);
    checkOutput("t6_ready", fReady98, 1);
    checkOutput("t6_over", fOver98, 0);
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
